cpu_writeback_arb: RTL and testbench

CPU_WRITEBACK_ARB -- requirements
Module: cpu_writeback_arb

---
 rtl/cpu_wb_pkg.sv | 22 ++
 rtl/cpu_wb_fifo.sv | 91 +++++++++
 rtl/cpu_writeback_arb.sv | 114 +++++++++++
 tb/tb_cpu_writeback_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_wb_pkg.sv
// Shared types and default parameters for the CPU writeback arbiter.
// Optional feature macro: WB_BYPASS_EN (see cpu_wb_fifo).
package cpu_wb_pkg;

  localparam int unsigned DefNumSrc    = 3;
  localparam int unsigned DefNumWports = 1;
  localparam int unsigned DefDataW     = 32;
  localparam int unsigned DefRegAddrW  = 5;
  localparam int unsigned DefFifoDepth = 2;

  // One writeback result at the default widths.
  typedef struct packed {
    logic [DefRegAddrW-1:0] rd;
    logic [DefDataW-1:0]    data;
  } wb_entry_t;

  // Single-step modulo for idx < 2*n.
  function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cpu_wb_fifo.sv
// Per-source writeback queue with registered ready and pending-register mask.
// Macro WB_BYPASS_EN: an input arriving at an empty queue is presented as head the same cycle.
module cpu_wb_fifo
  import cpu_wb_pkg::*;
#(
  parameter int unsigned DEPTH      = DefFifoDepth,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned REG_ADDR_W = DefRegAddrW
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [REG_ADDR_W-1:0]    rd_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     ready_o,
  input  logic                     pop_i,
  output logic                     head_valid_o,
  output logic [REG_ADDR_W-1:0]    head_rd_o,
  output logic [DATA_W-1:0]        head_data_o,
  output logic [2**REG_ADDR_W-1:0] pend_o
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  logic [PtrW:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]         count, count_d;
  logic                  ready_q, ready_d;
  logic                  empty, bypass, do_write, do_read;
  logic [REG_ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [DATA_W-1:0]     data_mem_q [DEPTH];
  logic [PtrW-1:0]       slot_off   [DEPTH];

  assign empty   = (wptr_q == rptr_q);
  assign count   = wptr_q - rptr_q;
  assign ready_o = ready_q;

`ifdef WB_BYPASS_EN
  assign head_valid_o = ~empty | push_i;
  assign head_rd_o    = empty ? rd_i   : rd_mem_q[rptr_q[PtrW-1:0]];
  assign head_data_o  = empty ? data_i : data_mem_q[rptr_q[PtrW-1:0]];
  // A granted input at an empty queue goes straight to the write port.
  assign bypass       = empty & push_i & pop_i;
`else
  assign head_valid_o = ~empty;
  assign head_rd_o    = rd_mem_q[rptr_q[PtrW-1:0]];
  assign head_data_o  = data_mem_q[rptr_q[PtrW-1:0]];
  assign bypass       = 1'b0;
`endif

  assign do_write = push_i & ~bypass;
  assign do_read  = pop_i & ~empty;

  always_comb begin
    wptr_d  = wptr_q + (PtrW + 1)'(do_write);
    rptr_d  = rptr_q + (PtrW + 1)'(do_read);
    count_d = wptr_d - rptr_d;
    ready_d = (count_d < DepthCnt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      rd_mem_q[wptr_q[PtrW-1:0]]   <= rd_i;
      data_mem_q[wptr_q[PtrW-1:0]] <= data_i;
    end
  end

  // A slot is live when its distance from the read pointer is below the fill count.
  always_comb begin
    pend_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_off[i] = PtrW'(i) - rptr_q[PtrW-1:0];
      if ({1'b0, slot_off[i]} < count) begin
        pend_o[rd_mem_q[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_writeback_arb.sv
// Round-robin arbiter from NUM_SRC result queues onto NUM_WPORTS register-file write ports.
// Macro WB_BYPASS_EN enables zero-latency bypass of empty queues.
module cpu_writeback_arb
  import cpu_wb_pkg::*;
#(
  parameter int unsigned NUM_SRC    = DefNumSrc,
  parameter int unsigned NUM_WPORTS = DefNumWports,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned REG_ADDR_W = DefRegAddrW,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_SRC-1:0]                 src_valid_i,
  output logic [NUM_SRC-1:0]                 src_ready_o,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]      src_rd_i,
  input  logic [NUM_SRC*DATA_W-1:0]          src_data_i,
  output logic [NUM_WPORTS-1:0]              wr_en_o,
  output logic [NUM_WPORTS*REG_ADDR_W-1:0]   wr_reg_o,
  output logic [NUM_WPORTS*DATA_W-1:0]       wr_data_o,
  output logic [2**REG_ADDR_W-1:0]           pend_mask_o
);

  localparam int unsigned RrW     = $clog2(NUM_SRC);
  localparam int unsigned NumRegs = 2**REG_ADDR_W;

  logic [NUM_SRC-1:0]    push, grant, head_valid;
  logic [REG_ADDR_W-1:0] head_rd   [NUM_SRC];
  logic [DATA_W-1:0]     head_data [NUM_SRC];
  logic [NumRegs-1:0]    src_pend  [NUM_SRC];
  logic [RrW-1:0]        rr_q, rr_d;

  logic                  port_en   [NUM_WPORTS];
  logic [REG_ADDR_W-1:0] port_rd   [NUM_WPORTS];
  logic [DATA_W-1:0]     port_data [NUM_WPORTS];

  int unsigned idx, nports;
  logic        conflict;

  assign push = src_valid_i & src_ready_o;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    cpu_wb_fifo #(
      .DEPTH      (FIFO_DEPTH),
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
    ) u_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (push[g]),
      .rd_i         (src_rd_i[g*REG_ADDR_W +: REG_ADDR_W]),
      .data_i       (src_data_i[g*DATA_W +: DATA_W]),
      .ready_o      (src_ready_o[g]),
      .pop_i        (grant[g]),
      .head_valid_o (head_valid[g]),
      .head_rd_o    (head_rd[g]),
      .head_data_o  (head_data[g]),
      .pend_o       (src_pend[g])
    );
  end

  // Scan from rr_q; a head whose rd matches an earlier grant this cycle waits.
  always_comb begin
    grant    = '0;
    rr_d     = rr_q;
    nports   = 0;
    idx      = 0;
    conflict = 1'b0;
    for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
      port_en[p]   = 1'b0;
      port_rd[p]   = '0;
      port_data[p] = '0;
    end
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx      = wrap_idx(int'(unsigned'(rr_q)) + k, NUM_SRC);
      conflict = 1'b0;
      for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
        if (p < nports && port_rd[p] == head_rd[idx]) begin
          conflict = 1'b1;
        end
      end
      if (head_valid[idx] && nports < NUM_WPORTS && !conflict) begin
        grant[idx]        = 1'b1;
        port_en[nports]   = 1'b1;
        port_rd[nports]   = head_rd[idx];
        port_data[nports] = head_data[idx];
        nports            = nports + 1;
        rr_d              = RrW'(wrap_idx(idx + 1, NUM_SRC));
      end
    end
  end

  for (genvar p = 0; p < NUM_WPORTS; p++) begin : g_port
    assign wr_en_o[p]                            = port_en[p];
    assign wr_reg_o[p*REG_ADDR_W +: REG_ADDR_W]  = port_rd[p];
    assign wr_data_o[p*DATA_W +: DATA_W]         = port_data[p];
  end

  always_comb begin
    pend_mask_o = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      pend_mask_o = pend_mask_o | src_pend[s];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: tb/tb_cpu_writeback_arb.sv
// Directed bench for cpu_writeback_arb: one default instance and one with two write ports.
module tb_cpu_writeback_arb;
  import cpu_wb_pkg::*;

  logic        clk;
  logic        rst_n;

  logic [2:0]  a_valid, a_ready;
  logic [14:0] a_rd;
  logic [95:0] a_data;
  logic [0:0]  a_wr_en;
  logic [4:0]  a_wr_reg;
  logic [31:0] a_wr_data;
  logic [31:0] a_pend;

  logic [2:0]  b_valid, b_ready;
  logic [14:0] b_rd;
  logic [95:0] b_data;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_reg;
  logic [63:0] b_wr_data;
  logic [31:0] b_pend;

  int n_assert = 0;
  int n_fail   = 0;

  wb_entry_t exp_q [3][$];

  cpu_writeback_arb u_dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .src_valid_i (a_valid),
    .src_ready_o (a_ready),
    .src_rd_i    (a_rd),
    .src_data_i  (a_data),
    .wr_en_o     (a_wr_en),
    .wr_reg_o    (a_wr_reg),
    .wr_data_o   (a_wr_data),
    .pend_mask_o (a_pend)
  );

  cpu_writeback_arb #(.NUM_WPORTS(2)) u_dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .src_valid_i (b_valid),
    .src_ready_o (b_ready),
    .src_rd_i    (b_rd),
    .src_data_i  (b_data),
    .wr_en_o     (b_wr_en),
    .wr_reg_o    (b_wr_reg),
    .wr_data_o   (b_wr_data),
    .pend_mask_o (b_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int s, input logic [4:0] rd, input logic [31:0] data);
    a_rd[s*5 +: 5]    = rd;
    a_data[s*32 +: 32] = data;
  endtask

  task automatic set_b(input int s, input logic [4:0] rd, input logic [31:0] data);
    b_rd[s*5 +: 5]    = rd;
    b_data[s*32 +: 32] = data;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    a_valid = '0;
    b_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    wb_entry_t e;
    int        g, rr, drained;
    logic [2:0] er;
    logic       found;

    rst_n   = 1'b0;
    a_valid = '0; a_rd = '0; a_data = '0;
    b_valid = '0; b_rd = '0; b_data = '0;
    #1;
    chk("rst_ready", a_ready, 3'b000);
    chk("rst_wr_en", a_wr_en, 1'b0);
    chk("rst_wr_reg", a_wr_reg, 5'd0);
    chk("rst_wr_data", a_wr_data, 32'd0);
    chk("rst_pend", a_pend, 32'd0);
    tick();
    rst_n = 1'b1;
    chk("ready_before_edge", a_ready, 3'b000);
    tick();
    chk("ready_after_release", a_ready, 3'b111);

    // MEM alone: rd=3, 0xDEADBEEF, one cycle of latency.
    set_a(1, 5'd3, 32'hDEADBEEF);
    a_valid = 3'b010;
    #1;
    chk("mem_pre_wr_en", a_wr_en, 1'b0);
    tick();
    a_valid = 3'b000;
    chk("mem_wr_en", a_wr_en, 1'b1);
    chk("mem_wr_reg", a_wr_reg, 5'd3);
    chk("mem_wr_data", a_wr_data, 32'hDEADBEEF);
    chk("mem_pend", a_pend, 32'h0000_0008);
    tick();
    chk("mem_done_wr_en", a_wr_en, 1'b0);
    chk("mem_done_pend", a_pend, 32'd0);

    // All three sources push every cycle for 12 cycles.
    do_reset();
    for (int s = 0; s < 3; s++) begin
      e.rd   = 5'((s * 10 + 1) % 32);
      e.data = {8'(s), 24'(1)};
      set_a(s, e.rd, e.data);
      exp_q[s].push_back(e);
    end
    a_valid = 3'b111;
    for (int k = 1; k <= 12; k++) begin
      tick();
      g  = (k - 1) % 3;
      er = (k == 1) ? 3'b111 : (3'b001 << ((k + 1) % 3));
      chk("rot_ready", a_ready, er);
      chk("rot_wr_en", a_wr_en, 1'b1);
      chk("rot_wr_reg", a_wr_reg, exp_q[g][0].rd);
      chk("rot_wr_data", a_wr_data, exp_q[g][0].data);
      void'(exp_q[g].pop_front());
      if (k < 12) begin
        for (int s = 0; s < 3; s++) begin
          e.rd   = 5'((s * 10 + k + 1) % 32);
          e.data = {8'(s), 24'(k + 1)};
          set_a(s, e.rd, e.data);
          if (er[s]) exp_q[s].push_back(e);
        end
      end else begin
        a_valid = 3'b000;
      end
    end
    rr      = 0;
    drained = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      found = 1'b0;
      for (int j = 0; j < 3 && !found; j++) begin
        g = (rr + j) % 3;
        if (exp_q[g].size() != 0) found = 1'b1;
      end
      if (!found) begin
        chk("drain_idle_wr_en", a_wr_en, 1'b0);
        break;
      end
      chk("drain_wr_reg", a_wr_reg, exp_q[g][0].rd);
      chk("drain_wr_data", a_wr_data, exp_q[g][0].data);
      void'(exp_q[g].pop_front());
      rr = (g + 1) % 3;
      drained++;
    end
    chk("drain_count", 64'(drained), 64'd4);
    chk("drain_pend", a_pend, 32'd0);

    // Two write ports, sources 0 and 1 both target rd=7.
    set_b(0, 5'd7, 32'hAAAA_0000);
    set_b(1, 5'd7, 32'hBBBB_1111);
    set_b(2, 5'd9, 32'hCCCC_2222);
    b_valid = 3'b111;
    #1;
    chk("dual_pre_wr_en", b_wr_en, 2'b00);
    tick();
    b_valid = 3'b000;
    chk("dual_wr_en", b_wr_en, 2'b11);
    chk("dual_wr_reg", b_wr_reg, {5'd9, 5'd7});
    chk("dual_wr_data", b_wr_data, {32'hCCCC_2222, 32'hAAAA_0000});
    chk("dual_pend", b_pend, 32'h0000_0280);
    tick();
    chk("dual2_wr_en", b_wr_en, 2'b01);
    chk("dual2_wr_reg", b_wr_reg, 10'd7);
    chk("dual2_wr_data", b_wr_data, {32'd0, 32'hBBBB_1111});
    chk("dual2_pend", b_pend, 32'h0000_0080);
    tick();
    chk("dual3_wr_en", b_wr_en, 2'b00);
    chk("dual3_pend", b_pend, 32'd0);

    // Source 2 pushes three back-to-back behind sources 0 and 1.
    do_reset();
    set_a(0, 5'd1, 32'h0000_0001);
    set_a(1, 5'd2, 32'h0000_0002);
    set_a(2, 5'd20, 32'hE000_0001);
    a_valid = 3'b111;
    tick();
    chk("starve1_wr_reg", a_wr_reg, 5'd1);
    chk("starve1_ready", a_ready, 3'b111);
    set_a(2, 5'd21, 32'hE000_0002);
    a_valid = 3'b100;
    tick();
    chk("starve2_wr_reg", a_wr_reg, 5'd2);
    chk("starve2_ready2", 64'(a_ready[2]), 64'd0);
    set_a(2, 5'd22, 32'hE000_0003);
    tick();
    chk("starve3_wr_data", a_wr_data, 32'hE000_0001);
    chk("starve3_ready2", 64'(a_ready[2]), 64'd0);
    tick();
    chk("starve4_wr_data", a_wr_data, 32'hE000_0002);
    chk("starve4_ready2", 64'(a_ready[2]), 64'd1);
    tick();
    a_valid = 3'b000;
    chk("starve5_wr_reg", a_wr_reg, 5'd22);
    chk("starve5_wr_data", a_wr_data, 32'hE000_0003);
    tick();
    chk("starve6_wr_en", a_wr_en, 1'b0);

    // Reset mid-burst with four entries queued.
    do_reset();
    set_a(0, 5'd10, 32'h1000_0000);
    set_a(1, 5'd11, 32'h1100_0000);
    set_a(2, 5'd12, 32'h1200_0000);
    a_valid = 3'b111;
    tick();
    set_a(1, 5'd13, 32'h1300_0000);
    set_a(2, 5'd14, 32'h1400_0000);
    a_valid = 3'b110;
    tick();
    a_valid = 3'b000;
    chk("burst_pend", a_pend, 32'h0000_7800);
    chk("burst_wr_reg", a_wr_reg, 5'd11);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", a_wr_en, 1'b0);
    chk("midrst_pend", a_pend, 32'd0);
    chk("midrst_ready", a_ready, 3'b000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_ready", a_ready, 3'b111);
    for (int i = 0; i < 3; i++) begin
      chk("postrst_wr_en", a_wr_en, 1'b0);
      chk("postrst_pend", a_pend, 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
